// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes,
// datapath select encodings and the control-word bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTEXE   = 4'd6,
        RTWB    = 4'd7,
        ADDIEXE = 4'd8,
        ADDIWB  = 4'd9,
        BRANCH  = 4'd10,
        JUMP    = 4'd11,
        FAULT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       fault;
    } ctrl_t;

    // States that wait on memory and therefore feed the watchdog.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control decode. The JUMP decode exists only when
// MC_JUMP_EN is defined.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   stall,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR, ADDIEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            RTEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`endif
            FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: ;
        endcase

        // A hazard freeze suppresses every architectural side effect.
        if (stall) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.reg_write     = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.mem_read      = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory-wait watchdog and retired
// counter. Define MC_JUMP_EN to build the j instruction.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    input  logic             stall,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int          WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT_CYCLES);

    state_t             state_reg;
    logic [WAIT_W-1:0]  wait_reg;
    logic [CNT_W-1:0]   retired_reg;
    logic               illegal_reg;
    ctrl_t              ctrl;
    logic               waiting;
    logic               timeout_hit;

    assign waiting     = is_mem_wait_state(state_reg) && !mem_ready && !stall;
    assign timeout_hit = (TIMEOUT_U != 32'd0) && ((32'(wait_reg) + 32'd1) >= TIMEOUT_U);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FETCH;
            wait_reg    <= '0;
            retired_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            illegal_reg <= 1'b0;
            if (!stall) begin
                if (waiting) begin
                    if (timeout_hit) begin
                        state_reg <= FAULT;
                        wait_reg  <= '0;
                    end else if (TIMEOUT_U != 32'd0) begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end else begin
                    // Any cycle that is not a memory wait either advances or
                    // sits in a non-memory state, so the wait count restarts.
                    wait_reg <= '0;
                    case (state_reg)
                        FETCH:   state_reg <= DECODE;
                        DECODE: begin
                            case (opcode)
                                OP_LW, OP_SW: state_reg <= MEMADR;
                                OP_RTYPE:     state_reg <= RTEXE;
                                OP_ADDI:      state_reg <= ADDIEXE;
                                OP_BEQ:       state_reg <= BRANCH;
`ifdef MC_JUMP_EN
                                OP_J:         state_reg <= JUMP;
`endif
                                default: begin
                                    state_reg   <= FETCH;
                                    illegal_reg <= 1'b1;
                                end
                            endcase
                        end
                        MEMADR:  state_reg <= (opcode == OP_SW) ? MEMWR : MEMRD;
                        MEMRD:   state_reg <= MEMWB;
                        RTEXE:   state_reg <= RTWB;
                        ADDIEXE: state_reg <= ADDIWB;
                        MEMWB, MEMWR, RTWB, ADDIWB, BRANCH: begin
                            state_reg   <= FETCH;
                            retired_reg <= retired_reg + 1'b1;
                        end
`ifdef MC_JUMP_EN
                        JUMP: begin
                            state_reg   <= FETCH;
                            retired_reg <= retired_reg + 1'b1;
                        end
`endif
                        FAULT:   state_reg <= FAULT;
                        default: state_reg <= FETCH;
                    endcase
                end
            end
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_reg),
        .mem_ready (mem_ready),
        .stall     (stall),
        .ctrl      (ctrl)
    );

    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign fault       = ctrl.fault;
    assign illegal_op  = illegal_reg;
    assign retired     = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model pushes
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_multicycle_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam int         MAXW    = 6;

    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_RX, P_RWB,
                      P_AX, P_AWB, P_BR, P_J, P_FLT} ph_t;

    typedef struct packed {
        logic        which;
        logic [17:0] ctrl;
        logic [31:0] ret;
        logic [31:0] idx;
    } exp_t;

    logic clk;
    logic rst, mem_ready, stall;
    logic [5:0] opcode;
    logic IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, PCWriteCond;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic illegal_op, fault;
    logic [31:0] retired;

    logic wd_rst, wd_mem_ready, wd_stall;
    logic [5:0] wd_opcode;
    logic wd_IorD, wd_MemRead, wd_MemWrite, wd_IRWrite, wd_RegDst, wd_MemtoReg, wd_RegWrite, wd_ALUSrcA, wd_PCWrite, wd_PCWriteCond;
    logic [1:0] wd_ALUOp, wd_ALUSrcB, wd_PCSource;
    logic wd_illegal_op, wd_fault;
    logic [31:0] wd_retired;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int issued = 0;
    logic        ill_exp = 1'b0;
    logic [31:0] ret_exp = '0;
    logic [31:0] wd_ret  = '0;

    multicycle_control #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .illegal_op(illegal_op), .fault(fault), .retired(retired)
    );

    multicycle_control #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut_wd (
        .clk(clk), .rst(wd_rst), .opcode(wd_opcode), .mem_ready(wd_mem_ready), .stall(wd_stall),
        .IorD(wd_IorD), .MemRead(wd_MemRead), .MemWrite(wd_MemWrite), .IRWrite(wd_IRWrite),
        .RegDst(wd_RegDst), .MemtoReg(wd_MemtoReg), .RegWrite(wd_RegWrite), .ALUSrcA(wd_ALUSrcA),
        .PCWrite(wd_PCWrite), .PCWriteCond(wd_PCWriteCond), .ALUOp(wd_ALUOp), .ALUSrcB(wd_ALUSrcB),
        .PCSource(wd_PCSource), .illegal_op(wd_illegal_op), .fault(wd_fault), .retired(wd_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for one cycle of an instruction phase.
    function automatic logic [15:0] ctrl_of(input ph_t p, input logic mr, input logic st);
        logic iord, mrd, mw, irw, rdst, m2r, rw, srca, pcw, pcwc;
        logic [1:0] aop, srcb, pcs;
        {iord, mrd, mw, irw, rdst, m2r, rw, srca, pcw, pcwc} = '0;
        aop = 2'b00; srcb = 2'b00; pcs = 2'b00;
        case (p)
            P_F:        begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
            P_D:        srcb = 2'b11;
            P_MA, P_AX: begin srca = 1'b1; srcb = 2'b10; end
            P_MR:       begin iord = 1'b1; mrd = 1'b1; end
            P_MW:       begin iord = 1'b1; mw = 1'b1; end
            P_MWB:      begin rw = 1'b1; m2r = 1'b1; end
            P_RX:       begin srca = 1'b1; aop = 2'b10; end
            P_RWB:      begin rw = 1'b1; rdst = 1'b1; end
            P_AWB:      rw = 1'b1;
            P_BR:       begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            P_J:        begin pcw = 1'b1; pcs = 2'b10; end
            default: ;
        endcase
        if (st) begin
            pcw = 1'b0; pcwc = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0; mrd = 1'b0;
        end
        return {iord, mrd, mw, irw, rdst, m2r, rw, srca, pcw, pcwc, aop, srcb, pcs};
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] r;
        case ($urandom_range(0, 7))
            0: r = T_LW;
            1: r = T_SW;
            2: r = T_RTYPE;
            3: r = T_ADDI;
            4: r = T_BEQ;
            5: r = T_J;
            default: r = 6'($urandom);
        endcase
        return r;
    endfunction

    // Drive one cycle's inputs, record what the DUT must show, advance a cycle.
    task automatic cycle(input logic which, input ph_t p, input logic mr, input logic st,
                         input logic [5:0] op, input logic ill, input logic [31:0] ret);
        exp_t e;
        if (which) begin
            wd_mem_ready = mr; wd_stall = st; wd_opcode = op;
        end else begin
            mem_ready = mr; stall = st; opcode = op;
        end
        e.which = which;
        e.ctrl  = {ctrl_of(p, mr, st), ill, (p == P_FLT)};
        e.ret   = ret;
        e.idx   = 32'(issued);
        issued++;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    // mode 0 random, 1 zero-wait, 2 three waits in MEMWR, 3 five-cycle stall in MEMRD.
    task automatic run_instr(input logic [5:0] op, input int mode, input int max_cycles);
        ph_t  ph[$];
        ph_t  p;
        int   idx, waits, stalls, ncyc;
        logic mr, st, mem, legal;
        ph.push_back(P_F);
        ph.push_back(P_D);
        case (op)
            T_LW:    begin ph.push_back(P_MA); ph.push_back(P_MR); ph.push_back(P_MWB); end
            T_SW:    begin ph.push_back(P_MA); ph.push_back(P_MW); end
            T_RTYPE: begin ph.push_back(P_RX); ph.push_back(P_RWB); end
            T_ADDI:  begin ph.push_back(P_AX); ph.push_back(P_AWB); end
            T_BEQ:   ph.push_back(P_BR);
`ifdef MC_JUMP_EN
            T_J:     ph.push_back(P_J);
`endif
            default: ;
        endcase
        legal = (ph.size() > 2);
        idx = 0; waits = 0; stalls = 0; ncyc = 0;
        while (idx < ph.size()) begin
            if (max_cycles > 0 && ncyc >= max_cycles) begin
                $display("instr op=%b abandoned after %0d cycles", op, ncyc);
                return;
            end
            p   = ph[idx];
            mem = (p == P_F) || (p == P_MR) || (p == P_MW);
            case (mode)
                0: begin
                    st = ($urandom_range(0, 7) == 0);
                    if (mem) mr = (waits >= MAXW) ? 1'b1 : 1'($urandom_range(0, 1));
                    else     mr = 1'($urandom_range(0, 1));
                end
                2:       begin st = 1'b0; mr = !(p == P_MW && waits < 3); end
                3:       begin st = (p == P_MR && stalls < 5); mr = 1'b1; end
                default: begin st = 1'b0; mr = 1'b1; end
            endcase
            cycle(1'b0, p, mr, st, op, ill_exp, ret_exp);
            ill_exp = 1'b0;
            ncyc++;
            if (st)              stalls++;
            else if (mem && !mr) waits++;
            else begin idx++; waits = 0; end
        end
        if (legal) ret_exp = ret_exp + 1;
        else       ill_exp = 1'b1;
        $display("instr op=%b cycles=%0d legal=%0d retired_exp=%0d", op, ncyc, legal, ret_exp);
    endtask

    task automatic do_reset(input logic which);
        if (which) begin
            wd_rst = 1'b1; wd_stall = 1'b1; wd_mem_ready = 1'b1;
        end else begin
            rst = 1'b1; stall = 1'b1; mem_ready = 1'b1;
        end
        @(posedge clk); #1;
        if (which) begin
            wd_rst = 1'b0; wd_ret = '0;
        end else begin
            rst = 1'b0; ret_exp = '0; ill_exp = 1'b0;
        end
        $display("reset dut%0d", which);
    endtask

    // Monitor: every cycle with an outstanding expectation is compared.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [17:0] act;
            logic [31:0] aret;
            e = exp_q.pop_front();
            if (e.which) begin
                act  = {wd_IorD, wd_MemRead, wd_MemWrite, wd_IRWrite, wd_RegDst, wd_MemtoReg,
                        wd_RegWrite, wd_ALUSrcA, wd_PCWrite, wd_PCWriteCond, wd_ALUOp, wd_ALUSrcB,
                        wd_PCSource, wd_illegal_op, wd_fault};
                aret = wd_retired;
            end else begin
                act  = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                        PCWrite, PCWriteCond, ALUOp, ALUSrcB, PCSource, illegal_op, fault};
                aret = retired;
            end
            checks++;
            if (act !== e.ctrl || aret !== e.ret) begin
                errors++;
                $display("FAIL cycle%0d dut%0d: got ctrl=%b retired=%0d, expected ctrl=%b retired=%0d",
                         e.idx, e.which, act, aret, e.ctrl, e.ret);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; stall = 1'b0; opcode = '0;
        wd_rst = 1'b1; wd_mem_ready = 1'b0; wd_stall = 1'b0; wd_opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(T_LW,    1, 0);
        run_instr(T_SW,    2, 0);
        run_instr(T_BEQ,   1, 0);
        run_instr(T_RTYPE, 1, 0);
        run_instr(6'b111111, 1, 0);
        run_instr(T_J,     1, 0);
        run_instr(T_LW,    3, 0);
        run_instr(T_ADDI,  1, 0);
        repeat (60) run_instr(rand_op(), 0, 0);

        run_instr(T_LW, 1, 3);
        do_reset(1'b0);
        run_instr(T_ADDI, 1, 0);

        // Watchdog instance: retire one beq, then starve FETCH until FAULT.
        do_reset(1'b1);
        cycle(1'b1, P_F,  1'b1, 1'b0, T_BEQ, 1'b0, wd_ret);
        cycle(1'b1, P_D,  1'b1, 1'b0, T_BEQ, 1'b0, wd_ret);
        cycle(1'b1, P_BR, 1'b1, 1'b0, T_BEQ, 1'b0, wd_ret);
        wd_ret = 32'd1;
        cycle(1'b1, P_F, 1'b0, 1'b1, T_BEQ, 1'b0, wd_ret);
        repeat (4) cycle(1'b1, P_F, 1'b0, 1'b0, T_BEQ, 1'b0, wd_ret);
        repeat (2) cycle(1'b1, P_FLT, 1'b1, 1'b0, T_BEQ, 1'b0, wd_ret);
        do_reset(1'b1);
        cycle(1'b1, P_F, 1'b0, 1'b0, T_BEQ, 1'b0, wd_ret);
        $display("watchdog sequence issued");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: memory-wait watchdog limit; 0 disables the watchdog.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port opcode, input, 6: instruction opcode from the instruction register (IR).
REQ-006 SHALL have port mem_ready, input, 1: memory has completed the current read or write this cycle.
REQ-007 SHALL have port stall, input, 1: hazard freeze.
REQ-008 SHALL have these 1-bit outputs: IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, PCWriteCond.
REQ-009 SHALL have these 2-bit outputs:
- ALUOp: 00 add, 01 sub, 10 funct.
- ALUSrcB: 00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- PCSource: 00 ALU, 01 ALUOut, 10 jump target.
REQ-010 SHALL have outputs illegal_op (1 bit), fault (1 bit) and retired (CNT_W bits).

Function
REQ-011 SHALL implement these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ADDIEXE, ADDIWB, BRANCH, JUMP, FAULT.
REQ-012 SHALL, in FETCH, drive MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00.
- IRWrite and PCWrite SHALL be 1 only in a cycle where mem_ready=1.
- The FSM SHALL leave FETCH for DECODE only when mem_ready=1.
REQ-013 SHALL, in DECODE, drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00, then branch on opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR.
- 000000 (R-type) -> RTEXE.
- 001000 (addi) -> ADDIEXE.
- 000100 (beq) -> BRANCH.
- 000010 (j) -> JUMP.
REQ-014 SHALL, in MEMADR and ADDIEXE, drive ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMADR -> MEMRD for lw, MEMWR for sw.
- ADDIEXE -> ADDIWB.
REQ-015 SHALL, in MEMRD, drive IorD=1 and MemRead=1, holding until mem_ready, then -> MEMWB.
- In MEMWR: IorD=1, MemWrite=1, holding until mem_ready, then -> FETCH.
REQ-016 SHALL drive these write-back states, each returning to FETCH:
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-017 SHALL, in RTEXE, drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then -> RTWB.
REQ-018 SHALL, in BRANCH, drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then -> FETCH.
REQ-019 SHALL, in JUMP, drive PCWrite=1 and PCSource=10, then -> FETCH.
REQ-020 SHALL drive every output not listed for a state to 0.
REQ-021 SHALL give these zero-wait latencies, counted from entry to FETCH until the next return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-022 SHALL handle an unrecognised opcode in DECODE as follows:
- Pulse illegal_op=1 for exactly one cycle.
- Go to FETCH.
- Leave retired unchanged.
REQ-023 SHALL increment retired by 1 on every completion transition to FETCH (from MEMWB, MEMWR, RTWB, ADDIWB, BRANCH or JUMP); it wraps from 2^CNT_W-1 to 0.
REQ-024 SHALL respond to stall=1 in any state as follows:
- State, wait counter and retired hold.
- PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite and MemRead are forced to 0.
- A mem_ready arriving during stall is ignored.
REQ-025 SHALL run the watchdog as follows:
- A wait counter counts consecutive cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0 and stall=0.
- The counter clears on every state change.
- If TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES, the FSM goes to FAULT.
REQ-026 SHALL, in FAULT, drive fault=1 and all control outputs 0, and SHALL leave FAULT only on rst.
REQ-027 SHALL treat mem_ready received while not in a memory state as don't-care.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set state=FETCH, wait counter=0, retired=0, fault=0 and illegal_op=0; rst overrides stall and mem_ready.
REQ-029 SHALL, in the first cycle after rst deasserts, present FETCH outputs (MemRead=1); asserting rst mid-instruction abandons that instruction without incrementing retired.

Configuration
REQ-030 SHALL, with macro MC_JUMP_EN defined, decode opcode 000010 to JUMP as specified; without it, JUMP is not built and 000010 is treated as an illegal opcode per REQ-022.

Structure
REQ-031 SHALL place the following in shared package mc_ctrl_pkg: the state enum, opcode constants, and the ALUOp, ALUSrcB and PCSource encodings.
REQ-032 SHALL implement the state-to-output decode as sub-module mc_ctrl_outdec (combinational, state+mem_ready+stall in, controls out); registers stay in multicycle_control.

Verification
REQ-033 SHALL cover: lw with mem_ready always 1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; RegWrite=MemtoReg=1 in MEMWB; retired 0->1.
REQ-034 SHALL cover: sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 and IorD=1 held for 4 cycles; no fault (TIMEOUT_CYCLES=16).
REQ-035 SHALL cover: beq then R-type back-to-back -> PCWriteCond=1 for exactly 1 cycle with ALUOp=01; RTWB has RegDst=1; retired=2.
REQ-036 SHALL cover: opcode 111111 -> illegal_op pulse of 1 cycle, return to FETCH, retired unchanged; likewise 000010 with MC_JUMP_EN undefined.
REQ-037 SHALL cover: stall=1 for 5 cycles in MEMRD with mem_ready=1 -> state held, MemRead=0, RegWrite never 1; resumes to MEMWB after release.
REQ-038 SHALL cover: TIMEOUT_CYCLES=4 with mem_ready held 0 in FETCH -> FAULT after 4 cycles with fault=1; rst -> FETCH, fault=0, retired=0.
